// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - sequences multi-cycle MULT/DIV/FPU operations with stall, start and writeback pulses
module multicycle_sequencer #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 8,
    parameter int FADD_LAT = 3,
    parameter int FMUL_LAT = 4,
    parameter int FDIV_LAT = 10
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       issue,
    input  logic       FPUorALU,
    input  logic [4:0] ALUOp,
    input  logic [3:0] FPUOpcode,
    input  logic       RegWrite,
    input  logic       FloatingPointWriteEnable,
    input  logic       Halted,
    output logic       stall,
    output logic       op_start,
    output logic       busy,
    output logic       wb_int,
    output logic       wb_fp,
    output logic       halt_ack
);

    // Operation encodings shared with the decoder
    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_MULT   = 5'd2;
    localparam logic [4:0] ALU_DIV    = 5'd3;
    localparam logic [3:0] FPU_ADD    = 4'd0;
    localparam logic [3:0] FPU_SUB    = 4'd1;
    localparam logic [3:0] FPU_MULT   = 4'd2;
    localparam logic [3:0] FPU_DIV    = 4'd3;
    localparam logic [3:0] FPU_NEGATE = 4'd4;

    localparam int MAX_A   = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int MAX_B   = (FADD_LAT > FMUL_LAT) ? FADD_LAT : FMUL_LAT;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_LAT = (MAX_C > FDIV_LAT) ? MAX_C : FDIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    // Counter preloads: the issue cycle and the DONE cycle are not counted
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 2);
    localparam logic [CNT_W-1:0] FADD_CNT = CNT_W'(FADD_LAT - 2);
    localparam logic [CNT_W-1:0] FMUL_CNT = CNT_W'(FMUL_LAT - 2);
    localparam logic [CNT_W-1:0] FDIV_CNT = CNT_W'(FDIV_LAT - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } seqState_t;

    seqState_t        state;
    logic [CNT_W-1:0] cnt;
    logic             pendInt;
    logic             pendFp;
    logic             isMulti;
    logic [CNT_W-1:0] loadCnt;

    // Classify the decoded instruction and pick its counter preload
    always_comb begin
        isMulti = 1'b0;
        loadCnt = '0;
        if (issue) begin
            if (!FPUorALU) begin
                case (ALUOp)
                    ALU_MULT: begin isMulti = 1'b1; loadCnt = MULT_CNT; end
                    ALU_DIV:  begin isMulti = 1'b1; loadCnt = DIV_CNT;  end
                    default:  ;
                endcase
            end else begin
                case (FPUOpcode)
                    FPU_ADD, FPU_SUB: begin isMulti = 1'b1; loadCnt = FADD_CNT; end
                    FPU_MULT:         begin isMulti = 1'b1; loadCnt = FMUL_CNT; end
                    FPU_DIV:          begin isMulti = 1'b1; loadCnt = FDIV_CNT; end
                    default:          ;
                endcase
            end
        end
    end

    // Handshake outputs: stall/start react in the issue cycle, everything masked in reset
    always_comb begin
        op_start = rst_b && (state == IDLE) && isMulti;
        stall    = rst_b && (((state == IDLE) && isMulti) || (state == BUSY));
        busy     = rst_b && (state == BUSY);
        wb_int   = rst_b && (state == DONE) && pendInt;
        wb_fp    = rst_b && (state == DONE) && pendFp;
    end

    // Sequencer FSM, latency counter, pending writeback flags and sticky halt
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state    <= IDLE;
            cnt      <= '0;
            pendInt  <= 1'b0;
            pendFp   <= 1'b0;
            halt_ack <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue && Halted) begin
                        halt_ack <= 1'b1;
                    end
                    if (isMulti) begin
                        pendInt <= RegWrite;
                        pendFp  <= FloatingPointWriteEnable;
                        cnt     <= loadCnt;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
